cpu_param_bus_if: RTL

Writer side of the transducer drive-parameter interface. The block takes asynchronous CPU bus strobes and decodes them into double-buffered per-transducer CYCLE, DUTY and PHASE arrays and a STEP value. Those outputs feed the silent LPF and the PWM generators in place of constants. The CPU commits a shadow bank to the active outputs either immediately or aligned to the next ultrasound period START.

---
 rtl/cpu_param_bus_if_if.sv | 20 ++
 rtl/cpu_param_bus_if.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_param_bus_if_if.sv
// CPU parameter bus as seen by the transducer parameter writer.
interface cpu_param_bus_if_if;
    logic        CPU_CS_N;
    logic        CPU_WE_N;
    logic        CPU_RD_N;
    logic [15:0] CPU_ADDR;
    logic [15:0] CPU_DATA_IN;
    logic [15:0] CPU_DATA_OUT;
    logic        CPU_DATA_OE;

    modport master (
        output CPU_CS_N, CPU_WE_N, CPU_RD_N, CPU_ADDR, CPU_DATA_IN,
        input  CPU_DATA_OUT, CPU_DATA_OE
    );

    modport slave (
        input  CPU_CS_N, CPU_WE_N, CPU_RD_N, CPU_ADDR, CPU_DATA_IN,
        output CPU_DATA_OUT, CPU_DATA_OE
    );
endinterface

// File: rtl/cpu_param_bus_if.sv
// Writer side of the transducer drive-parameter interface: async CPU bus to
// double-buffered CYCLE/DUTY/PHASE arrays plus STEP, committed now or at START.
module cpu_param_bus_if #(
    parameter int unsigned TRANS_NUM     = 249,
    parameter int unsigned WIDTH         = 13,
    parameter int unsigned DEFAULT_CYCLE = 5000,
    parameter int unsigned DEFAULT_STEP  = 100
) (
    input  logic              CLK,
    input  logic              RESET_N,
    cpu_param_bus_if_if.slave bus,
    input  logic              START,
    output logic [WIDTH-1:0]  STEP,
    output logic [WIDTH-1:0]  CYCLE [TRANS_NUM],
    output logic [WIDTH-1:0]  DUTY  [TRANS_NUM],
    output logic [WIDTH-1:0]  PHASE [TRANS_NUM],
    output logic              UPDATE
);

    localparam int unsigned AW    = (TRANS_NUM > 1) ? $clog2(TRANS_NUM) : 1;
    localparam int unsigned BUS_W = 16;

    typedef enum logic {ST_IDLE = 1'b0, ST_PENDING = 1'b1} state_t;

    logic [1:0]            r_cs_s;
    logic [1:0]            r_we_s;
    logic [1:0]            r_rd_s;
    logic                  r_we_q;
    logic                  r_rd_q;
    logic                  r_start_q;
    logic [1:0][BUS_W-1:0] r_addr_d;
    logic [1:0][BUS_W-1:0] r_data_d;

    logic                  r_wr_pulse;
    logic                  r_rd_pulse;
    logic [BUS_W-1:0]      r_acc_addr;
    logic [BUS_W-1:0]      r_acc_data;

    logic [WIDTH-1:0]      r_sh_cycle [TRANS_NUM];
    logic [WIDTH-1:0]      r_sh_duty  [TRANS_NUM];
    logic [WIDTH-1:0]      r_sh_phase [TRANS_NUM];
    logic [WIDTH-1:0]      r_act_cycle [TRANS_NUM];
    logic [WIDTH-1:0]      r_act_duty  [TRANS_NUM];
    logic [WIDTH-1:0]      r_act_phase [TRANS_NUM];
    logic [WIDTH-1:0]      r_step;
    logic                  r_mode;
    logic                  r_commit_req;
    state_t                r_state;
    logic                  r_update;
    logic [BUS_W-1:0]      r_data_out;
    logic                  r_oe;

    logic                  w_we_rise;
    logic                  w_rd_fall;
    logic [3:0]            w_region;
    logic [11:0]           w_idx;
    logic [AW-1:0]         w_ent;
    logic                  w_in_range;
    logic [WIDTH-1:0]      w_wdata;
    logic                  w_do_commit;
    logic [BUS_W-1:0]      w_rd_word;
    logic                  w_unused_data;

    // Two-flop strobe synchronizers; address/data delayed to stay aligned.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cs_s    <= 2'b11;
            r_we_s    <= 2'b11;
            r_rd_s    <= 2'b11;
            r_we_q    <= 1'b1;
            r_rd_q    <= 1'b1;
            r_start_q <= 1'b0;
            r_addr_d  <= '0;
            r_data_d  <= '0;
        end else begin
            r_cs_s    <= {r_cs_s[0], bus.CPU_CS_N};
            r_we_s    <= {r_we_s[0], bus.CPU_WE_N};
            r_rd_s    <= {r_rd_s[0], bus.CPU_RD_N};
            r_we_q    <= r_we_s[1];
            r_rd_q    <= r_rd_s[1];
            r_start_q <= START;
            r_addr_d  <= {r_addr_d[0], bus.CPU_ADDR};
            r_data_d  <= {r_data_d[0], bus.CPU_DATA_IN};
        end
    end

    // A simultaneous WE low suppresses the read so the write wins.
    assign w_we_rise = r_we_s[1] & ~r_we_q & ~r_cs_s[1];
    assign w_rd_fall = ~r_rd_s[1] & r_rd_q & ~r_cs_s[1] & r_we_s[1];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr_pulse <= 1'b0;
            r_rd_pulse <= 1'b0;
            r_acc_addr <= '0;
            r_acc_data <= '0;
        end else begin
            r_wr_pulse <= w_we_rise;
            r_rd_pulse <= w_rd_fall;
            r_acc_addr <= r_addr_d[1];
            r_acc_data <= r_data_d[1];
        end
    end

    assign w_region      = r_acc_addr[15:12];
    assign w_idx         = r_acc_addr[11:0];
    assign w_ent         = w_idx[AW-1:0];
    assign w_in_range    = (w_idx < 12'(TRANS_NUM));
    assign w_wdata       = r_acc_data[WIDTH-1:0];
    assign w_unused_data = ^(r_acc_data >> WIDTH);

    // Shadow arrays, STEP and control register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int unsigned i = 0; i < TRANS_NUM; i++) begin
                r_sh_cycle[AW'(i)] <= WIDTH'(DEFAULT_CYCLE);
                r_sh_duty[AW'(i)]  <= '0;
                r_sh_phase[AW'(i)] <= '0;
            end
            r_step       <= WIDTH'(DEFAULT_STEP);
            r_mode       <= 1'b0;
            r_commit_req <= 1'b0;
        end else begin
            r_commit_req <= 1'b0;
            if (r_wr_pulse) begin
                case (w_region)
                    4'h0: begin
                        case (w_idx)
                            12'd0: begin
                                r_mode       <= r_acc_data[1];
                                r_commit_req <= r_acc_data[0];
                            end
                            12'd1:   r_step <= w_wdata;
                            default: ;
                        endcase
                    end
                    4'h1: if (w_in_range) r_sh_cycle[w_ent] <= w_wdata;
                    4'h2: if (w_in_range) r_sh_duty[w_ent]  <= w_wdata;
                    4'h3: if (w_in_range) r_sh_phase[w_ent] <= w_wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_do_commit = 1'b0;
        case (r_state)
            ST_IDLE:    w_do_commit = r_commit_req & ~r_mode;
            ST_PENDING: w_do_commit = (r_commit_req & ~r_mode) | r_start_q;
            default:    w_do_commit = 1'b0;
        endcase
    end

    // Commit FSM; copies see the pre-write shadow when a write lands on the same edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state  <= ST_IDLE;
            r_update <= 1'b0;
            for (int unsigned i = 0; i < TRANS_NUM; i++) begin
                r_act_cycle[AW'(i)] <= WIDTH'(DEFAULT_CYCLE);
                r_act_duty[AW'(i)]  <= '0;
                r_act_phase[AW'(i)] <= '0;
            end
        end else begin
            r_update <= w_do_commit;
            if (w_do_commit) begin
                r_act_cycle <= r_sh_cycle;
                r_act_duty  <= r_sh_duty;
                r_act_phase <= r_sh_phase;
            end
            case (r_state)
                ST_IDLE: begin
                    if (r_commit_req && r_mode) r_state <= ST_PENDING;
                end
                ST_PENDING: begin
                    if (w_do_commit) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_rd_word = '0;
        case (w_region)
            4'h0: begin
                case (w_idx)
                    12'd0:   w_rd_word = {14'd0, r_mode, 1'b0};
                    12'd1:   w_rd_word = BUS_W'(r_step);
                    12'd2:   w_rd_word = {15'd0, (r_state == ST_PENDING)};
                    default: w_rd_word = '0;
                endcase
            end
            4'h1:    if (w_in_range) w_rd_word = BUS_W'(r_sh_cycle[w_ent]);
            4'h2:    if (w_in_range) w_rd_word = BUS_W'(r_sh_duty[w_ent]);
            4'h3:    if (w_in_range) w_rd_word = BUS_W'(r_sh_phase[w_ent]);
            default: w_rd_word = '0;
        endcase
    end

    // Read data is held while RD_N stays low and cleared once it rises.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_data_out <= '0;
            r_oe       <= 1'b0;
        end else begin
            r_oe <= ~r_cs_s[0] & ~r_rd_s[0];
            if (r_rd_pulse) begin
                r_data_out <= w_rd_word;
            end else if (r_rd_s[1]) begin
                r_data_out <= '0;
            end
        end
    end

    assign bus.CPU_DATA_OUT = r_data_out;
    assign bus.CPU_DATA_OE  = r_oe;
    assign STEP             = r_step;
    assign CYCLE            = r_act_cycle;
    assign DUTY             = r_act_duty;
    assign PHASE            = r_act_phase;
    assign UPDATE           = r_update;

endmodule
